// File: rtl/irrigation_sequencer.sv
// rtl/irrigation_sequencer.sv - timed FILL/IRRIGATE/REST irrigation sequencer with latched level-sensor FAULT
// Optional FILL_TIMEOUT_EN: FILL faults after FILL_TIMEOUT_TICKS ticks without reaching the high level.
module irrigation_sequencer #(
  parameter int IRRIGATE_TICKS     = 8,
  parameter int REST_TICKS         = 4,
  parameter int FILL_TIMEOUT_TICKS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       low_water_level,
  input  logic       mid_water_level,
  input  logic       high_water_level,
  input  logic       earth_humidity,
  input  logic       air_humidity,
  input  logic       low_temperature,
  input  logic       fault_clear,
  output logic       water_supply_valvule,
  output logic       splinker_bomb,
  output logic       dripper_valvule,
  output logic       alarm,
  output logic [2:0] state,
  output logic       cycle_done
);

  localparam int MAX_AB    = (IRRIGATE_TICKS > REST_TICKS) ? IRRIGATE_TICKS : REST_TICKS;
  localparam int MAX_TICKS = (MAX_AB > FILL_TIMEOUT_TICKS) ? MAX_AB : FILL_TIMEOUT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_IRRIGATE = 3'd2,
    S_REST     = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  state_t        cur, nxt;
  logic [CW-1:0] count;
  logic          splinker_mode;
  logic          conflict;
  logic          expire;
  logic          done_next;

  // A higher level sensor wet while a lower one is dry can only be a sensor fault.
  assign conflict = (high_water_level & ~mid_water_level) | (mid_water_level & ~low_water_level);
  assign expire   = tick && (count == CW'(1));

  always_comb begin
    nxt       = cur;
    done_next = 1'b0;
    if (conflict) begin
      nxt = S_FAULT;
    end else begin
      case (cur)
        S_IDLE: begin
          if (!earth_humidity) nxt = high_water_level ? S_IRRIGATE : S_FILL;
        end
        S_FILL: begin
          if (high_water_level) nxt = S_IRRIGATE;
`ifdef FILL_TIMEOUT_EN
          else if (expire) nxt = S_FAULT;
`endif
        end
        S_IRRIGATE: begin
          if (!low_water_level)   nxt = S_FILL;
          else if (earth_humidity) nxt = S_REST;
          else if (expire)         nxt = S_REST;
        end
        S_REST: begin
          if (expire) begin
            nxt       = S_IDLE;
            done_next = 1'b1;
          end
        end
        S_FAULT: begin
          if (fault_clear) nxt = S_IDLE;
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur        <= S_IDLE;
      cycle_done <= 1'b0;
    end else begin
      cur        <= nxt;
      cycle_done <= done_next;
    end
  end

  // Counter reloads on the entering edge, so a coincident tick is not counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count         <= '0;
      splinker_mode <= 1'b0;
    end else if (nxt != cur) begin
      case (nxt)
        S_IRRIGATE: begin
          count         <= CW'(IRRIGATE_TICKS);
          splinker_mode <= mid_water_level & ~air_humidity & ~low_temperature;
        end
        S_REST:  count <= CW'(REST_TICKS);
`ifdef FILL_TIMEOUT_EN
        S_FILL:  count <= CW'(FILL_TIMEOUT_TICKS);
`endif
        default: count <= '0;
      endcase
    end else if (tick && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign state                = cur;
  assign water_supply_valvule = (cur == S_FILL);
  assign splinker_bomb        = (cur == S_IRRIGATE) &&  splinker_mode;
  assign dripper_valvule      = (cur == S_IRRIGATE) && !splinker_mode;
  assign alarm                = (cur == S_FAULT);

endmodule

// File: tb/tb_irrigation_sequencer.sv
// tb/tb_irrigation_sequencer.sv - scoreboard bench for irrigation_sequencer
module tb_irrigation_sequencer;
  localparam logic [7:0] E_IDLE  = 8'b000_00000;
  localparam logic [7:0] E_FILL  = 8'b001_10000;
  localparam logic [7:0] E_SPL   = 8'b010_01000;
  localparam logic [7:0] E_DRP   = 8'b010_00100;
  localparam logic [7:0] E_REST  = 8'b011_00000;
  localparam logic [7:0] E_FAULT = 8'b100_00010;
  localparam logic [7:0] E_DONE  = 8'b000_00001;

  logic clock = 1'b0, reset = 1'b1, tick = 1'b0;
  logic low_water_level = 1'b0, mid_water_level = 1'b0, high_water_level = 1'b0;
  logic earth_humidity = 1'b1, air_humidity = 1'b0, low_temperature = 1'b0, fault_clear = 1'b0;
  logic water_supply_valvule, splinker_bomb, dripper_valvule, alarm, cycle_done;
  logic [2:0] state;
  logic [7:0] obs, e;
  logic [7:0] exp_q[$];
  int checks = 0, errors = 0;

  irrigation_sequencer dut (
    .clock(clock), .reset(reset), .tick(tick),
    .low_water_level(low_water_level), .mid_water_level(mid_water_level),
    .high_water_level(high_water_level), .earth_humidity(earth_humidity),
    .air_humidity(air_humidity), .low_temperature(low_temperature),
    .fault_clear(fault_clear), .water_supply_valvule(water_supply_valvule),
    .splinker_bomb(splinker_bomb), .dripper_valvule(dripper_valvule),
    .alarm(alarm), .state(state), .cycle_done(cycle_done)
  );

  always #5 clock = ~clock;
  assign obs = {state, water_supply_valvule, splinker_bomb, dripper_valvule, alarm, cycle_done};

  task automatic cyc(input logic t);
    tick = t;
    @(posedge clock);
    #1;
    tick = 1'b0;
  endtask

  task automatic set_levels(input logic [2:0] lmh);
    {low_water_level, mid_water_level, high_water_level} = lmh;
  endtask

  task automatic test_reset;
    exp_q.push_back(E_IDLE);
    repeat (2) @(posedge clock);
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, e); end
    checks++;
    if (dut.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", dut.count); end
    reset = 1'b0;
    exp_q.push_back(E_IDLE);
    cyc(0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_release: got %b expected %b", obs, e); end
  endtask

  task automatic test_splinker_cycle;
    earth_humidity = 1'b0; set_levels(3'b111); air_humidity = 1'b0; low_temperature = 1'b0;
    exp_q.push_back(E_SPL);
    cyc(0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL spl_entry: got %b expected %b", obs, e); end
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        exp_q.push_back((k == 7 && j == 3) ? E_REST : E_SPL);
        cyc(j == 3);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL spl_run tick%0d clk%0d: got %b expected %b", k, j, obs, e); end
      end
    end
    earth_humidity = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        exp_q.push_back((k == 3 && j == 3) ? E_DONE : E_REST);
        cyc(j == 3);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL spl_rest tick%0d clk%0d: got %b expected %b", k, j, obs, e); end
      end
    end
    exp_q.push_back(E_IDLE);
    cyc(0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL spl_done_once: got %b expected %b", obs, e); end
  endtask

  task automatic test_dripper_reload;
    logic [2:0] lv[6]  = '{3'b100, 3'b110, 3'b111, 3'b111, 3'b111, 3'b111};
    logic [7:0] ex[6]  = '{E_FILL, E_FILL, E_DRP, E_DRP, E_DRP, E_DRP};
    air_humidity = 1'b1; earth_humidity = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_levels(lv[i]);
      exp_q.push_back(ex[i]);
      cyc(i >= 3);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL drp_step%0d: got %b expected %b", i, obs, e); end
    end
    checks++;
    if (dut.count !== 5'd5) begin errors++; $display("FAIL drp_count5: got %0d expected 5", dut.count); end
    set_levels(3'b000);
    exp_q.push_back(E_FILL);
    cyc(0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL drp_low_drop: got %b expected %b", obs, e); end
    set_levels(3'b111);
    exp_q.push_back(E_DRP);
    cyc(0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL drp_reentry: got %b expected %b", obs, e); end
    checks++;
    if (dut.count !== 5'd8) begin errors++; $display("FAIL drp_reload: got %0d expected 8", dut.count); end
    earth_humidity = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(i == 0 ? E_REST : i < 4 ? E_REST : i == 4 ? E_DONE : E_IDLE);
      cyc(i < 5);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL drp_rest%0d: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_fault;
    logic [2:0] lv[6] = '{3'b101, 3'b101, 3'b111, 3'b011, 3'b011, 3'b111};
    logic       fc[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] ex[6] = '{E_FAULT, E_FAULT, E_IDLE, E_FAULT, E_FAULT, E_IDLE};
    earth_humidity = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_levels(lv[i]); fault_clear = fc[i];
      exp_q.push_back(ex[i]);
      cyc(0);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL fault_step%0d: got %b expected %b", i, obs, e); end
    end
    fault_clear = 1'b0;
  endtask

  task automatic test_priority;
    logic [2:0] lv[8] = '{3'b111, 3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b101};
    logic       ea[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       tk[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] ex[8] = '{E_SPL, E_FILL, E_SPL, E_REST, E_REST, E_REST, E_REST, E_FAULT};
    air_humidity = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_levels(lv[i]); earth_humidity = ea[i];
      exp_q.push_back(ex[i]);
      cyc(tk[i]);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL prio_step%0d: got %b expected %b", i, obs, e); end
    end
    set_levels(3'b111); fault_clear = 1'b1;
    exp_q.push_back(E_IDLE);
    cyc(0);
    fault_clear = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL prio_clear: got %b expected %b", obs, e); end
  endtask

  task automatic test_reset_midphase;
    earth_humidity = 1'b0; set_levels(3'b111); air_humidity = 1'b0;
    cyc(0);
    repeat (5) cyc(1);
    checks++;
    if (dut.count !== 5'd3 || obs !== E_SPL) begin
      errors++; $display("FAIL midrst_pre: got %b/%0d expected %b/3", obs, dut.count, E_SPL);
    end
    earth_humidity = 1'b1;
    #1 reset = 1'b1;
    exp_q.push_back(8'h00);
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL midrst_async: got %b expected %b", obs, e); end
    @(posedge clock);
    #1;
    checks++;
    if (dut.count !== 5'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", dut.count); end
    reset = 1'b0;
    exp_q.push_back(E_IDLE);
    cyc(0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL midrst_release: got %b expected %b", obs, e); end
  endtask

  task automatic test_fill_timeout;
    earth_humidity = 1'b0; set_levels(3'b100);
    exp_q.push_back(E_FILL);
    cyc(1);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL fill_entry: got %b expected %b", obs, e); end
`ifdef FILL_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(i == 16 ? E_FAULT : E_FILL);
`else
    for (int i = 1; i <= 100; i++) begin
      exp_q.push_back(E_FILL);
`endif
      cyc(1);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL fill_wait tick%0d: got %b expected %b", i, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_splinker_cycle();
    test_dripper_reload();
    test_fault();
    test_priority();
    test_reset_midphase();
    test_fill_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
